// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI transfer engine between ADC capture (req 0)
// and DAC playback (req 1), with a start/transfer watchdog and registered outputs.
module spi_xfer_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int START_TIMEOUT = 8,
    parameter int XFER_TIMEOUT  = 64,
    parameter int TMR_WIDTH     = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [DATA_WIDTH-1:0] tx_data0,
    input  logic [DATA_WIDTH-1:0] tx_data1,
    output logic [1:0]            ack,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  err,
    output logic                  busy,
    output logic                  xfer_start,
    output logic                  xfer_sel,
    output logic [DATA_WIDTH-1:0] xfer_tx,
    input  logic [DATA_WIDTH-1:0] xfer_rx,
    input  logic                  xfer_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_LOW = 3'd2,
        BUSY     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [TMR_WIDTH-1:0] START_LAST = TMR_WIDTH'(START_TIMEOUT - 1);
    localparam logic [TMR_WIDTH-1:0] XFER_LAST  = TMR_WIDTH'(XFER_TIMEOUT - 1);
    localparam logic [TMR_WIDTH-1:0] TMR_MAX    = {TMR_WIDTH{1'b1}};

    state_t                  state_q;
    logic                    last_grant_q;
    logic                    timeout_q;
    logic [TMR_WIDTH-1:0]    tmr_q;
    logic [1:0]              ack_q;
    logic                    err_q;
    logic                    busy_q;
    logic                    xfer_start_q;
    logic                    xfer_sel_q;
    logic [DATA_WIDTH-1:0]   xfer_tx_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;

    logic                    grant_d;
    logic [DATA_WIDTH-1:0]   xfer_tx_d;
    logic [TMR_WIDTH-1:0]    tmr_d;
    logic [1:0]              ack_d;

    // A lone request wins outright; a tie goes to whoever was not served last.
    always_comb begin
        grant_d = req[1];
        if (req == 2'b11) begin
            grant_d = ~last_grant_q;
        end
        xfer_tx_d = grant_d ? tx_data1 : tx_data0;
        tmr_d     = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
        ack_d     = xfer_sel_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            timeout_q    <= 1'b0;
            tmr_q        <= '0;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            xfer_start_q <= 1'b0;
            xfer_sel_q   <= 1'b0;
            xfer_tx_q    <= '0;
            rx_data_q    <= '0;
        end else begin
            xfer_start_q <= 1'b0;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A reset may have left the engine mid-transfer, so never grant until it is idle.
                    if (xfer_done && (req != 2'b00)) begin
                        xfer_sel_q <= grant_d;
                        xfer_tx_q  <= xfer_tx_d;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    xfer_start_q <= 1'b1;
                    tmr_q        <= '0;
                    state_q      <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!xfer_done) begin
                        tmr_q   <= '0;
                        state_q <= BUSY;
                    end else if (tmr_q == START_LAST) begin
                        timeout_q <= 1'b1;
                        ack_q     <= ack_d;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                BUSY: begin
                    if (xfer_done) begin
                        rx_data_q <= xfer_rx;
                        ack_q     <= ack_d;
                        err_q     <= timeout_q;
                        state_q   <= DONE;
                    end else if (tmr_q == XFER_LAST) begin
                        timeout_q <= 1'b1;
                        ack_q     <= ack_d;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                DONE: begin
                    last_grant_q <= xfer_sel_q;
                    timeout_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign rx_data    = rx_data_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign xfer_start = xfer_start_q;
    assign xfer_sel   = xfer_sel_q;
    assign xfer_tx    = xfer_tx_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized scoreboard bench for spi_xfer_arbiter: a request-level model predicts the
// service order and response of every transfer; a monitor checks what the DUT presents.
module tb_spi_xfer_arbiter;

    localparam int DW            = 16;
    localparam int START_TIMEOUT = 8;
    localparam int XFER_TIMEOUT  = 64;

    logic          clk;
    logic          rst;
    logic [1:0]    req;
    logic [DW-1:0] tx_data0;
    logic [DW-1:0] tx_data1;
    logic [1:0]    ack;
    logic [DW-1:0] rx_data;
    logic          err;
    logic          busy;
    logic          xfer_start;
    logic          xfer_sel;
    logic [DW-1:0] xfer_tx;
    logic [DW-1:0] xfer_rx;
    logic          xfer_done;

    spi_xfer_arbiter #(
        .DATA_WIDTH   (DW),
        .START_TIMEOUT(START_TIMEOUT),
        .XFER_TIMEOUT (XFER_TIMEOUT),
        .TMR_WIDTH    (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tx_data0  (tx_data0),
        .tx_data1  (tx_data1),
        .ack       (ack),
        .rx_data   (rx_data),
        .err       (err),
        .busy      (busy),
        .xfer_start(xfer_start),
        .xfer_sel  (xfer_sel),
        .xfer_tx   (xfer_tx),
        .xfer_rx   (xfer_rx),
        .xfer_done (xfer_done)
    );

    // kind: 0 = completed, 1 = engine never started, 2 = engine stayed busy too long
    typedef struct {
        logic          sel;
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
        logic          err;
        int            kind;
    } exp_t;

    typedef struct {
        bit            never;
        int            len;
        logic [DW-1:0] rx;
    } eng_t;

    exp_t exp_q[$];
    eng_t eng_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic m_last = 1'b1;
    logic [DW-1:0] m_rx = '0;
    bit   started = 0;
    bit   eng_busy = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: each granted transfer is fully determined by who is served and how the engine behaves.
    task automatic predict(input logic sel, input logic [DW-1:0] tx, input eng_t e);
        exp_t x;
        x.sel = sel;
        x.tx  = tx;
        if (e.never) begin
            x.err = 1'b1; x.rx = m_rx; x.kind = 1;
        end else if (e.len > XFER_TIMEOUT) begin
            x.err = 1'b1; x.rx = m_rx; x.kind = 2;
        end else begin
            x.err = 1'b0; x.rx = e.rx; x.kind = 0; m_rx = e.rx;
        end
        m_last = sel;
        exp_q.push_back(x);
        eng_q.push_back(e);
    endtask

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic wait_ack(input logic [1:0] mask, output logic [1:0] got);
        got = 2'b00;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((ack & mask) != 2'b00) begin
                got = ack & mask;
                break;
            end
        end
        if (got == 2'b00) begin
            errors++;
            checks++;
            $display("FAIL ack_wait: got no ack, expected ack on mask %b within 400 cycles", mask);
            finish_now();
        end
    endtask

    task automatic run_round(input logic [1:0] pat, input logic [DW-1:0] t0, input logic [DW-1:0] t1,
                             input eng_t ea, input eng_t eb);
        logic       first;
        logic [1:0] pending;
        logic [1:0] got;
        tx_data0 = t0;
        tx_data1 = t1;
        first = (pat == 2'b11) ? ~m_last : pat[1];
        predict(first, first ? t1 : t0, ea);
        if (pat == 2'b11) predict(~first, first ? t0 : t1, eb);
        req = pat;
        pending = pat;
        while (pending != 2'b00) begin
            wait_ack(pending, got);
            @(posedge clk); #1;
            req = req & ~got;
            pending = pending & ~got;
        end
    endtask

    function automatic eng_t rand_eng();
        eng_t e;
        int   r;
        r = $urandom_range(0, 9);
        e.never = (r == 0);
        e.len   = (r == 1) ? $urandom_range(66, 80) : $urandom_range(1, 15);
        e.rx    = DW'($urandom);
        return e;
    endfunction

    task automatic fairness();
        eng_t       e;
        logic       s;
        logic [1:0] got;
        tx_data0 = DW'($urandom);
        tx_data1 = DW'($urandom);
        s = ~m_last;
        for (int k = 0; k < 6; k++) begin
            e.never = 0; e.len = $urandom_range(2, 12); e.rx = DW'($urandom);
            predict(s, s ? tx_data1 : tx_data0, e);
            s = ~s;
        end
        req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_ack(2'b11, got);
            @(posedge clk); #1;
            if (k == 5) req = 2'b00;
            else req = req & ~got;
            if (k < 5) begin
                @(posedge clk); #1;
                req = req | got;
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(xfer_start), 32'd0);
        chk({tag, "_sel"}, 32'(xfer_sel), 32'd0);
        chk({tag, "_tx"}, 32'(xfer_tx), 32'd0);
        chk({tag, "_rx"}, 32'(rx_data), 32'd0);
    endtask

    task automatic idle_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("idle_reset");
        m_last = 1'b1;
        m_rx   = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Engine model: drops done the cycle after it sees a start, holds it low for len cycles.
    initial begin
        eng_t cur;
        int   cnt;
        logic st;
        cnt = 0;
        cur.never = 0; cur.len = 0; cur.rx = '0;
        xfer_done = 1'b1;
        xfer_rx   = '0;
        forever begin
            @(negedge clk);
            st = xfer_start;
            @(posedge clk); #1;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    xfer_done = 1'b1;
                    xfer_rx   = cur.rx;
                    eng_busy  = 0;
                end
            end else if (st && eng_q.size() > 0) begin
                cur = eng_q.pop_front();
                if (!cur.never) begin
                    xfer_done = 1'b0;
                    xfer_rx   = DW'($urandom);
                    cnt       = cur.len;
                    eng_busy  = 1;
                end
            end
        end
    end

    // Monitor: compares every start and every ack against the head of the expectation queue.
    initial begin
        exp_t x;
        logic prev_done;
        int   cyc_start, cyc_fall, cyc_rise;
        bit   ok;
        prev_done = 1'b1;
        cyc_start = 0; cyc_fall = 0; cyc_rise = 0;
        forever begin
            @(negedge clk);
            if (prev_done && !xfer_done) cyc_fall = cyc;
            if (!prev_done && xfer_done) cyc_rise = cyc;
            prev_done = xfer_done;
            if (!rst) begin
                if (xfer_start) begin
                    chk("start_engine_idle", 32'(xfer_done), 32'd1);
                    ok = (exp_q.size() > 0) && !started;
                    chk("start_expected", 32'(ok), 32'd1);
                    if (ok) begin
                        started   = 1;
                        cyc_start = cyc;
                        x = exp_q[0];
                        chk("start_sel", 32'(xfer_sel), 32'(x.sel));
                        chk("start_tx", 32'(xfer_tx), 32'(x.tx));
                    end
                end
                if (ack != 2'b00) begin
                    ok = (exp_q.size() > 0) && started;
                    chk("ack_expected", 32'(ok), 32'd1);
                    if (ok) begin
                        x = exp_q.pop_front();
                        started = 0;
                        chk("ack_bits", 32'(ack), x.sel ? 32'd2 : 32'd1);
                        chk("ack_rx", 32'(rx_data), 32'(x.rx));
                        chk("ack_err", 32'(err), 32'(x.err));
                        chk("ack_tx_stable", 32'(xfer_tx), 32'(x.tx));
                        chk("ack_busy", 32'(busy), 32'd1);
                        if (x.kind == 0) chk("ack_after_done", 32'(cyc - cyc_rise), 32'd1);
                        else if (x.kind == 1) chk("start_timeout_lat", 32'(cyc - cyc_start), 32'(START_TIMEOUT));
                        // done low is first sampled at the end of its first low cycle
                        else chk("busy_timeout_lat", 32'(cyc - cyc_fall), 32'(XFER_TIMEOUT + 1));
                    end
                end
            end
        end
    end

    initial begin
        eng_t ea, eb;
        logic [1:0] pat;
        logic [1:0] got;
        logic [DW-1:0] t1;
        rst = 1'b1;
        req = 2'b00;
        tx_data0 = '0;
        tx_data1 = '0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // single request with fixed data
        ea.never = 0; ea.len = 10; ea.rx = 16'h1234;
        eb = ea;
        run_round(2'b01, 16'hA5A5, 16'h0000, ea, eb);

        // simultaneous request right after reset: requester 0 first
        idle_reset();
        ea.never = 0; ea.len = 5; ea.rx = DW'($urandom);
        eb.never = 0; eb.len = 7; eb.rx = DW'($urandom);
        run_round(2'b11, DW'($urandom), DW'($urandom), ea, eb);

        fairness();

        // engine never acknowledges the start
        ea.never = 1; ea.len = 0; ea.rx = DW'($urandom);
        run_round(2'b01, DW'($urandom), DW'($urandom), ea, ea);

        // engine stuck busy, then a follow-up request must wait for it
        ea.never = 0; ea.len = 100; ea.rx = DW'($urandom);
        run_round(2'b10, DW'($urandom), DW'($urandom), ea, ea);
        ea.len = 4; ea.rx = DW'($urandom);
        run_round(2'b01, DW'($urandom), DW'($urandom), ea, ea);

        // longest transfer that still completes, and the first that times out
        ea.len = XFER_TIMEOUT; ea.rx = DW'($urandom);
        run_round(2'b01, DW'($urandom), DW'($urandom), ea, ea);
        ea.len = XFER_TIMEOUT + 1; ea.rx = DW'($urandom);
        run_round(2'b10, DW'($urandom), DW'($urandom), ea, ea);

        for (int r = 0; r < 20; r++) begin
            pat = 2'($urandom_range(1, 3));
            run_round(pat, DW'($urandom), DW'($urandom), rand_eng(), rand_eng());
        end

        // reset while BUSY: no ack, pending req=10 served once the engine frees up
        repeat (120) @(posedge clk);
        #1;
        ea.never = 0; ea.len = 40; ea.rx = DW'($urandom);
        t1 = DW'($urandom);
        tx_data1 = t1;
        predict(1'b1, t1, ea);
        req = 2'b10;
        for (int i = 0; i < 20 && xfer_done; i++) @(negedge clk);
        chk("engine_went_busy", 32'(xfer_done), 32'd0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("busy_reset");
        void'(exp_q.pop_front());
        started = 0;
        m_last = 1'b1;
        m_rx   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ea.len = 6; ea.rx = DW'($urandom);
        predict(1'b1, t1, ea);
        wait_ack(2'b10, got);
        @(posedge clk); #1;
        req = 2'b00;

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        finish_now();
    end

endmodule
